// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared types and width helper for the input conditioner
package input_cond_pkg;

    typedef enum logic [0:0] {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } debounce_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// rtl/strobe_gen.sv - free-running counter emitting a one-cycle strobe every PERIOD cycles
module strobe_gen
    import input_cond_pkg::*;
#(
    parameter int PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic strobe
);

    localparam int W = cnt_width(PERIOD);
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            strobe <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - key synchronizer, debouncer and enable-strobe front end
// Define INPUT_COND_STROBE_ALIGN_EN to hold key_level updates until the next strobe.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int STROBE_PERIOD   = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic strobe,
    output logic key_level,
    output logic key_press
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);

    logic            sync1;
    logic            sync2;
    debounce_state_e state;
    debounce_state_e state_next;
    logic [DW-1:0]   cnt;
    logic [DW-1:0]   cnt_next;
    logic            db_level;
    logic            db_level_next;
    logic            level_q;

    strobe_gen #(
        .PERIOD(STROBE_PERIOD)
    ) u_strobe_gen (
        .clk   (clk),
        .reset (reset),
        .strobe(strobe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_raw ^ KEY_ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DB_STABLE;
            cnt      <= '0;
            db_level <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            db_level <= db_level_next;
        end
    end

    // A new value is accepted only after DEBOUNCE_CYCLES+1 agreeing samples.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        db_level_next = db_level;
        case (state)
            DB_STABLE: begin
                if (sync2 != db_level) begin
                    state_next = DB_CHANGING;
                    cnt_next   = DW'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            DB_CHANGING: begin
                if (sync2 == db_level) begin
                    state_next = DB_STABLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    db_level_next = sync2;
                    state_next    = DB_STABLE;
                    cnt_next      = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = DB_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef INPUT_COND_STROBE_ALIGN_EN
    // The latest accepted value becomes visible together with the strobe.
    assign key_level = strobe ? db_level : level_q;
`else
    assign key_level = db_level;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= 1'b0;
            key_press <= 1'b0;
        end else begin
            level_q   <= key_level;
            key_press <= key_level & ~level_q;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench: directed table, async reset, random vs model
module tb_input_conditioner;

    localparam int P  = 5;
    localparam int D  = 4;
    localparam int NV = 40;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic key_raw = 1'b1;
    logic strobe;
    logic key_level;
    logic key_press;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit raw;
        bit exp_strobe;
        bit exp_level;
        bit exp_press;
    } vec_t;

    vec_t tbl [NV];

    // Reference model: edge count since reset release and logical key history.
    bit kh [$];
    int n;
    bit m_db;
    bit m_lvl;
    bit m_lvl_prev;
    bit m_press;
    bit m_strobe;

    input_conditioner #(
        .STROBE_PERIOD  (P),
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .strobe   (strobe),
        .key_level(key_level),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Logical key value sampled at edge i; flops hold 0 before release.
    function automatic bit kget(input int i);
        return (i < 1) ? 1'b0 : kh[i-1];
    endfunction

    function automatic bit table_raw(input int e);
        if (e <= 2)  return 1'b1;
        if (e <= 14) return (((e - 3) / 2) % 2 == 0) ? 1'b0 : 1'b1;
        if (e <= 30) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        kh.delete();
        n          = 0;
        m_db       = 1'b0;
        m_lvl      = 1'b0;
        m_lvl_prev = 1'b0;
        m_press    = 1'b0;
        m_strobe   = 1'b0;
    endtask

    // Level flips once the synchronized input has disagreed for D+1 edges in a row.
    task automatic model_edge(input bit k);
        bit all_new;
        n++;
        kh.push_back(k);
        all_new = 1'b1;
        for (int j = 0; j <= D; j++)
            if (kget(n - 2 - j) == m_db) all_new = 1'b0;
        if (all_new) m_db = ~m_db;
        m_strobe   = (n % P == 0);
        m_press    = m_lvl & ~m_lvl_prev;
        m_lvl_prev = m_lvl;
`ifdef INPUT_COND_STROBE_ALIGN_EN
        if (m_strobe) m_lvl = m_db;
`else
        m_lvl = m_db;
`endif
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%b expected=%b", name, n, act, exp);
        end
    endtask

    task automatic apply_edge(input bit raw);
        key_raw = raw;
        @(posedge clk);
        model_edge(~raw);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_strobe"}, strobe, m_strobe);
        check({tag, "_level"}, key_level, m_lvl);
        check({tag, "_press"}, key_press, m_press);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_strobe", strobe, 1'b0);
        check("in_reset_level", key_level, 1'b0);
        check("in_reset_press", key_press, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    initial begin
        bit rv;
        int len;

        for (int i = 0; i < NV; i++) begin
            tbl[i].raw        = table_raw(i + 1);
            tbl[i].exp_strobe = ((i + 1) % P == 0);
            tbl[i].exp_level  = (i + 1 >= 21) && (i + 1 < 37);
            tbl[i].exp_press  = (i + 1 == 22);
        end

        key_raw = 1'b1;
        do_reset();
        check("release_strobe", strobe, 1'b0);
        check("release_level", key_level, 1'b0);
        check("release_press", key_press, 1'b0);

        // Bouncy press, clean hold, then release.
        for (int i = 0; i < NV; i++) begin
            apply_edge(tbl[i].raw);
            check("tbl_strobe", strobe, tbl[i].exp_strobe);
`ifndef INPUT_COND_STROBE_ALIGN_EN
            check("tbl_level", key_level, tbl[i].exp_level);
            check("tbl_press", key_press, tbl[i].exp_press);
`endif
            check_model("tbl_model");
        end

        // Press, then start a release and kill it with an async reset mid-count.
        repeat (12) begin
            apply_edge(1'b0);
            check_model("press");
        end
        repeat (4) begin
            apply_edge(1'b1);
            check_model("release_partial");
        end
        check("pre_reset_level", key_level, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("async_strobe", strobe, 1'b0);
        check("async_level", key_level, 1'b0);
        check("async_press", key_press, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (12) begin
            apply_edge(1'b0);
            check_model("restart");
        end

        // Randomized runs of constant key_raw, including glitches of 1 edge.
        key_raw = 1'b1;
        do_reset();
        for (int r = 0; r < 150; r++) begin
            rv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                apply_edge(rv);
                check_model("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
